// File: rtl/freq_counter_poller.sv
// AXI4-Lite master that enables a FrequencyCounter core and polls its count register, strobing each valid count.
// Optional per-transfer watchdog enabled by defining FREQ_POLL_TIMEOUT_EN.
module freq_counter_poller #(
  parameter logic [15:0] CtrlAddr_Gen      = 16'h0000,
  parameter logic [15:0] CountAddr_Gen     = 16'h0004,
  parameter int          PollCycles_Gen    = 1000,
  parameter int          TimeoutCycles_Gen = 65535
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic        Enable_EnaIn,
  input  logic [7:0]  Period_DatIn,
  output logic        AxiWriteAddrValid_ValOut,
  input  logic        AxiWriteAddrReady_RdyIn,
  output logic [15:0] AxiWriteAddrAddress_AdrOut,
  output logic [2:0]  AxiWriteAddrProt_DatOut,
  output logic        AxiWriteDataValid_ValOut,
  input  logic        AxiWriteDataReady_RdyIn,
  output logic [31:0] AxiWriteDataData_DatOut,
  output logic [3:0]  AxiWriteDataStrobe_DatOut,
  input  logic        AxiWriteRespValid_ValIn,
  output logic        AxiWriteRespReady_RdyOut,
  input  logic [1:0]  AxiWriteRespResponse_DatIn,
  output logic        AxiReadAddrValid_ValOut,
  input  logic        AxiReadAddrReady_RdyIn,
  output logic [15:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]  AxiReadAddrProt_DatOut,
  input  logic        AxiReadDataValid_ValIn,
  output logic        AxiReadDataReady_RdyOut,
  input  logic [1:0]  AxiReadDataResponse_DatIn,
  input  logic [31:0] AxiReadDataData_DatIn,
  output logic [30:0] Frequency_DatOut,
  output logic        Frequency_ValOut,
  output logic        Error_ErrOut
);

  typedef enum logic [2:0] {IDLE, WR_CTRL, WR_RESP, POLL_WAIT, RD_ADDR, RD_DATA} state_e;

  localparam int PollW = (PollCycles_Gen > 2) ? $clog2(PollCycles_Gen) : 1;

  state_e             state_q, state_d;
  logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [7:0]         period_q, period_d;
  logic               awvalid_q, awvalid_d;
  logic [15:0]        awaddr_q, awaddr_d;
  logic               wvalid_q, wvalid_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic [15:0]        araddr_q, araddr_d;
  logic               rready_q, rready_d;
  logic [30:0]        freq_q, freq_d;
  logic               freq_vld_q, freq_vld_d;
  logic               err_q, err_d;

`ifdef FREQ_POLL_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles_Gen + 1);
  logic [ToW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    period_d   = period_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rready_d   = rready_q;
    freq_d     = freq_q;
    freq_vld_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (Enable_EnaIn) begin
          state_d   = WR_CTRL;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = CtrlAddr_Gen;
          wdata_d   = {16'h0, Period_DatIn, 7'h0, 1'b1};
          period_d  = Period_DatIn;
          err_d     = 1'b0;
        end
      end
      WR_CTRL: begin
        if (AxiWriteAddrReady_RdyIn) awvalid_d = 1'b0;
        if (AxiWriteDataReady_RdyIn) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (AxiWriteRespValid_ValIn) begin
          bready_d   = 1'b0;
          poll_cnt_d = '0;
          if (AxiWriteRespResponse_DatIn != 2'b00) err_d = 1'b1;
          state_d = wdata_q[0] ? POLL_WAIT : IDLE;
        end
      end
      POLL_WAIT: begin
        // Disable wins over a period change; both reuse the control write path.
        if (!Enable_EnaIn || (Period_DatIn != period_q)) begin
          state_d   = WR_CTRL;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = CtrlAddr_Gen;
          wdata_d   = Enable_EnaIn ? {16'h0, Period_DatIn, 7'h0, 1'b1} : 32'h0;
          period_d  = Period_DatIn;
        end else if (poll_cnt_q == PollW'(PollCycles_Gen - 1)) begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = CountAddr_Gen;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      RD_ADDR: begin
        if (AxiReadAddrReady_RdyIn) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (AxiReadDataValid_ValIn) begin
          rready_d   = 1'b0;
          poll_cnt_d = '0;
          state_d    = POLL_WAIT;
          if (AxiReadDataResponse_DatIn != 2'b00) begin
            err_d = 1'b1;
          end else if (AxiReadDataData_DatIn[31]) begin
            freq_d     = AxiReadDataData_DatIn[30:0];
            freq_vld_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FREQ_POLL_TIMEOUT_EN
    // Watchdog only flags the error; the pending handshake is still awaited.
    wd_cnt_d = '0;
    if (state_q != IDLE && state_q != POLL_WAIT && state_d == state_q) begin
      wd_cnt_d = (wd_cnt_q != ToW'(TimeoutCycles_Gen)) ? wd_cnt_q + 1'b1 : wd_cnt_q;
      if (wd_cnt_q == ToW'(TimeoutCycles_Gen - 1)) err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state_q    <= IDLE;
      poll_cnt_q <= '0;
      period_q   <= '0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      freq_q     <= '0;
      freq_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      period_q   <= period_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
      freq_q     <= freq_d;
      freq_vld_q <= freq_vld_d;
      err_q      <= err_d;
    end
  end

`ifdef FREQ_POLL_TIMEOUT_EN
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) wd_cnt_q <= '0;
    else                wd_cnt_q <= wd_cnt_d;
  end
`endif

  assign AxiWriteAddrValid_ValOut   = awvalid_q;
  assign AxiWriteAddrAddress_AdrOut = awaddr_q;
  assign AxiWriteAddrProt_DatOut    = 3'b000;
  assign AxiWriteDataValid_ValOut   = wvalid_q;
  assign AxiWriteDataData_DatOut    = wdata_q;
  assign AxiWriteDataStrobe_DatOut  = 4'hF;
  assign AxiWriteRespReady_RdyOut   = bready_q;
  assign AxiReadAddrValid_ValOut    = arvalid_q;
  assign AxiReadAddrAddress_AdrOut  = araddr_q;
  assign AxiReadAddrProt_DatOut     = 3'b000;
  assign AxiReadDataReady_RdyOut    = rready_q;
  assign Frequency_DatOut           = freq_q;
  assign Frequency_ValOut           = freq_vld_q;
  assign Error_ErrOut               = err_q;

endmodule
